// File: rtl/aidc_lite_pkg.sv
// aidc_lite_pkg: register offsets, LEN granularity and control FSM states shared by the AIDC Lite config block.
package aidc_lite_pkg;
  localparam int OFF_VERSION     = 'h000;
  localparam int OFF_SRC_ADDR    = 'h100;
  localparam int OFF_DST_ADDR    = 'h104;
  localparam int OFF_LEN         = 'h108;
  localparam int OFF_CMD         = 'h10C;
  localparam int OFF_STATUS      = 'h110;
  localparam int OFF_IRQ_EN      = 'h114;
  localparam int OFF_IRQ_STATUS  = 'h118;
  localparam int OFF_PERF_CYCLES = 'h11C;
  localparam int LEN_LSB = 7;
  typedef enum logic {S_CFG_IDLE, S_CFG_BUSY} cfg_state_e;
endpackage

// File: rtl/aidc_lite_cfg.sv
// aidc_lite_cfg: APB3 register block for the AIDC Lite engine (addresses, length, start, done tracking, irq).
// Define AIDC_LITE_CFG_PERF_CNT_EN to add the PERF_CYCLES busy-cycle counter at 0x11C.
module aidc_lite_cfg
  import aidc_lite_pkg::*;
#(
  parameter logic [31:0] VERSION = 32'h0001_0000,
  parameter int          ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o,
  output logic [24:0]       len_o,
  output logic              start_o,
  input  logic              done_i,
  output logic              irq_o
);
  cfg_state_e state_q;
  logic [31:0] src_q, dst_q;
  logic [31:LEN_LSB] len_q;
  logic start_q, sts_done_q, done_i_q, irq_en_q, irq_st_q;
`ifdef AIDC_LITE_CFG_PERF_CNT_EN
  logic [31:0] perf_q;
`endif
  logic acc, busy, hit_src, hit_dst, hit_len, hit_cmd, hit_ien, hit_ist;
  logic mapped, ro, err, wr_ok, done_rise;
  logic [31:0] rdata;
  assign acc       = psel_i & penable_i;
  assign busy      = state_q == S_CFG_BUSY;
  assign hit_src   = paddr_i == ADDR_W'(OFF_SRC_ADDR);
  assign hit_dst   = paddr_i == ADDR_W'(OFF_DST_ADDR);
  assign hit_len   = paddr_i == ADDR_W'(OFF_LEN);
  assign hit_cmd   = paddr_i == ADDR_W'(OFF_CMD);
  assign hit_ien   = paddr_i == ADDR_W'(OFF_IRQ_EN);
  assign hit_ist   = paddr_i == ADDR_W'(OFF_IRQ_STATUS);
  assign done_rise = done_i & ~done_i_q;
  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    ro     = 1'b0;
    case (paddr_i)
      ADDR_W'(OFF_VERSION):    begin rdata = VERSION; ro = 1'b1; end
      ADDR_W'(OFF_SRC_ADDR):   rdata = src_q;
      ADDR_W'(OFF_DST_ADDR):   rdata = dst_q;
      ADDR_W'(OFF_LEN):        rdata = {len_q, {LEN_LSB{1'b0}}};
      ADDR_W'(OFF_CMD):        rdata = '0;
      ADDR_W'(OFF_STATUS):     begin rdata = {30'b0, sts_done_q, busy}; ro = 1'b1; end
      ADDR_W'(OFF_IRQ_EN):     rdata = {31'b0, irq_en_q};
      ADDR_W'(OFF_IRQ_STATUS): rdata = {31'b0, irq_st_q};
`ifdef AIDC_LITE_CFG_PERF_CNT_EN
      ADDR_W'(OFF_PERF_CYCLES): begin rdata = perf_q; ro = 1'b1; end
`endif
      default:                 mapped = 1'b0;
    endcase
  end
  // Engine-facing config is frozen while busy; a start with zero length is rejected.
  assign err = acc & (~mapped | (pwrite_i & (ro | (busy & (hit_src | hit_dst | hit_len | hit_cmd))
                                             | (hit_cmd & pwdata_i[0] & ~|len_q))));
  assign wr_ok      = acc & pwrite_i & ~err;
  assign prdata_o   = (acc & ~err) ? rdata : '0;
  assign pslverr_o  = err;
  assign pready_o   = 1'b1;
  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;
  assign len_o      = len_q;
  assign start_o    = start_q;
  assign irq_o      = irq_st_q & irq_en_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CFG_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      start_q    <= 1'b0;
      sts_done_q <= 1'b0;
      done_i_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_st_q   <= 1'b0;
`ifdef AIDC_LITE_CFG_PERF_CNT_EN
      perf_q     <= '0;
`endif
    end else begin
      done_i_q <= done_i;
      start_q  <= 1'b0;
      if (wr_ok & hit_src) src_q <= pwdata_i;
      if (wr_ok & hit_dst) dst_q <= pwdata_i;
      if (wr_ok & hit_len) len_q <= pwdata_i[31:LEN_LSB];
      if (wr_ok & hit_ien) irq_en_q <= pwdata_i[0];
      if (wr_ok & hit_ist & pwdata_i[0]) irq_st_q <= 1'b0;
      case (state_q)
        S_CFG_IDLE: if (wr_ok & hit_cmd & pwdata_i[0]) begin
          start_q    <= 1'b1;
          sts_done_q <= 1'b0;
          state_q    <= S_CFG_BUSY;
`ifdef AIDC_LITE_CFG_PERF_CNT_EN
          perf_q     <= '0;
`endif
        end
        S_CFG_BUSY: begin
`ifdef AIDC_LITE_CFG_PERF_CNT_EN
          perf_q <= perf_q + {31'b0, ~&perf_q};
`endif
          // Placed after the W1C so a coincident completion keeps the flag set.
          if (done_rise) begin
            sts_done_q <= 1'b1;
            irq_st_q   <= 1'b1;
            state_q    <= S_CFG_IDLE;
          end
        end
        default: state_q <= S_CFG_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aidc_lite_cfg.sv
// tb_aidc_lite_cfg: scoreboard bench with a register-level reference model and random APB/done stimulus.
module tb_aidc_lite_cfg;
  logic clk = 0, rst_n = 0, psel = 0, penable = 0, pwrite = 0, done_i = 0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata, src_o, dst_o;
  logic [24:0] len_o;
  logic pready, pslverr, start_o, irq_o;

  aidc_lite_cfg dut (
    .clk(clk), .rst_n(rst_n), .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .src_addr_o(src_o), .dst_addr_o(dst_o), .len_o(len_o),
    .start_o(start_o), .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, starts = 0, m_starts = 0;
  logic prev_start = 0;
  typedef struct packed {logic w; logic [11:0] a; logic [31:0] r; logic e;} exp_t;
  exp_t q[$];
  exp_t x;

  logic [31:0] m_src, m_dst, m_len, m_perf;
  bit m_busy, m_done, m_ien, m_ist, dn_acc;
  longint m_g;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic longint edge_idx();
    return (longint'($time) - 5) / 10;
  endfunction

  task automatic model_reset();
    m_src = 0; m_dst = 0; m_len = 0; m_perf = 0;
    m_busy = 0; m_done = 0; m_ien = 0; m_ist = 0; m_g = 0;
  endtask

  // Register-map semantics; k is the index of the last clock edge before the access edge.
  task automatic model_apb(input bit w, input logic [11:0] a, input logic [31:0] d, input longint k,
                           output logic [31:0] r, output bit e, output bit go);
    r = 0; e = 0; go = 0;
    case (a)
      12'h000: if (w) e = 1; else r = 32'h0001_0000;
      12'h100: if (w) begin if (m_busy) e = 1; else m_src = d; end else r = m_src;
      12'h104: if (w) begin if (m_busy) e = 1; else m_dst = d; end else r = m_dst;
      12'h108: if (w) begin if (m_busy) e = 1; else m_len = d & 32'hFFFF_FF80; end else r = m_len;
      12'h10C: if (w) begin
        if (m_busy) e = 1;
        else if (d[0]) begin
          if (m_len == 0) e = 1;
          else begin go = 1; m_busy = 1; m_done = 0; m_perf = 0; m_g = k + 1; m_starts++; end
        end
      end
      12'h110: if (w) e = 1; else r = {30'b0, m_done, m_busy};
      12'h114: if (w) m_ien = d[0]; else r = {31'b0, m_ien};
      12'h118: if (w) begin if (d[0]) m_ist = 0; end else r = {31'b0, m_ist};
`ifdef AIDC_LITE_CFG_PERF_CNT_EN
      12'h11C: if (w) e = 1; else r = m_busy ? 32'(k - m_g) : m_perf;
`endif
      default: e = 1;
    endcase
    if (e) r = 0;
  endtask

  task automatic complete(input longint d);
    if (m_busy) begin m_perf = 32'(d - m_g); m_busy = 0; m_done = 1; m_ist = 1; end
  endtask

  task automatic check_outs();
    check("src_addr_o", src_o, m_src);
    check("dst_addr_o", dst_o, m_dst);
    check("len_o", {7'b0, len_o}, {7'b0, m_len[31:7]});
    check("irq_o", {31'b0, irq_o}, {31'b0, m_ist & m_ien});
  endtask

  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    bit e, go;
    longint k;
    @(posedge clk); #1 psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    k = edge_idx();
    model_apb(w, a, d, k, r, e, go);
    q.push_back('{w: w, a: a, r: r, e: e});
    if (dn_acc) begin
      dn_acc = 0; done_i = 1;
      complete(k + 1);
    end
    @(posedge clk); #1 psel = 0; penable = 0;
    check("start_pulse", {31'b0, start_o}, {31'b0, go});
    check_outs();
  endtask

  task automatic set_done(input bit v);
    bit prev;
    prev = done_i;
    @(posedge clk); #1 done_i = v;
    @(posedge clk);
    if (v && !prev) complete(edge_idx());
    #1 check("irq_after_done", {31'b0, irq_o}, {31'b0, m_ist & m_ien});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0; psel = 0; penable = 0; done_i = 0;
    repeat (3) @(posedge clk);
    #1 model_reset();
    check_outs();
    check("rst_start", {31'b0, start_o}, 0);
    check("rst_pready", {31'b0, pready}, 1);
    check("rst_pslverr", {31'b0, pslverr}, 0);
    check("rst_prdata", prdata, 0);
    rst_n = 1;
  endtask

  always @(negedge clk) if (rst_n && psel && penable) begin
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty actual=access required=queued t=%0t", $time);
    end else begin
      x = q.pop_front();
      check($sformatf("pslverr@%h", x.a), {31'b0, pslverr}, {31'b0, x.e});
      if (!x.w) check($sformatf("prdata@%h", x.a), prdata, x.r);
    end
  end

  always @(negedge clk) begin
    if (rst_n && start_o) begin
      starts++;
      check("start_width", {31'b0, prev_start}, 0);
    end
    prev_start = rst_n & start_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] addrs [12];
    logic [31:0] d;
    model_reset();
    dn_acc = 0;
    do_reset();
    apb(0, 12'h000, 0);
    apb(0, 12'h114, 0);
    apb(0, 12'h110, 0);
    apb(1, 12'h100, 32'h1000_0000);
    apb(1, 12'h104, 32'h2000_0000);
    apb(1, 12'h108, 32'h0000_0380);
    apb(1, 12'h10C, 1);
    apb(0, 12'h110, 0);
    apb(1, 12'h108, 32'h0000_0100);
    apb(1, 12'h10C, 1);
    apb(1, 12'h114, 1);
    apb(0, 12'h11C, 0);
    set_done(1);
    apb(0, 12'h110, 0);
    apb(1, 12'h118, 1);
    repeat (4) @(posedge clk);
    set_done(1);
    apb(0, 12'h110, 0);
    set_done(0);
    apb(1, 12'h108, 0);
    apb(1, 12'h10C, 1);
    apb(0, 12'h110, 0);
    apb(0, 12'h200, 0);
    apb(1, 12'h000, 32'hFFFF_FFFF);
    apb(1, 12'h108, 32'h0000_0080);
    apb(1, 12'h10C, 1);
    repeat (48) @(posedge clk);
    set_done(1);
    set_done(0);
    apb(0, 12'h11C, 0);
    apb(1, 12'h11C, 5);
    apb(1, 12'h10C, 1);
    dn_acc = 1;
    apb(1, 12'h118, 1);
    apb(0, 12'h118, 0);
    set_done(0);
    apb(1, 12'h10C, 1);
    do_reset();
    apb(0, 12'h110, 0);
    apb(0, 12'h108, 0);
    addrs = '{12'h000, 12'h100, 12'h104, 12'h108, 12'h10C, 12'h10C, 12'h110,
              12'h114, 12'h118, 12'h11C, 12'h200, 12'h102};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) set_done(~done_i);
      else begin
        logic [11:0] a;
        a = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 11)];
        d = $urandom;
        if (a == 12'h108 && $urandom_range(0, 3) == 0) d = d & 32'h7F;
        if (a == 12'h10C && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        apb(1'($urandom_range(0, 1)), a, d);
      end
    end
    repeat (2) @(posedge clk);
    #1 check("sb_drained", 32'(q.size()), 0);
    check("start_count", 32'(starts), 32'(m_starts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
